// File: rtl/emaxi_wr_checker.sv
`default_nettype none
// ============================================================================
// Module   : emaxi_wr_checker
// Brief    : Scoreboard that checks the AXI AW/W beats issued for accepted eMesh writes.
// Revision : 1.0 - initial release
// ============================================================================
module emaxi_wr_checker #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_access,
    input  logic                   wr_wait,
    input  logic [103:0]           wr_packet,
    input  logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    input  logic [31:0]            m_axi_awaddr,
    input  logic [7:0]             m_axi_awlen,
    input  logic [2:0]             m_axi_awsize,
    input  logic [1:0]             m_axi_awburst,
    input  logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic                   m_axi_wlast,
    input  logic [63:0]            m_axi_wdata,
    input  logic [7:0]             m_axi_wstrb,
    output logic                   err_addr,
    output logic                   err_data,
    output logic                   err_proto,
    output logic                   err_timeout,
    output logic                   err_overflow,
    output logic                   err_unexpected,
    output logic [$clog2(DEPTH):0] pending,
    output logic [CW-1:0]          match_cnt
);

    localparam int c_iw = $clog2(DEPTH);
    localparam int c_pw = c_iw + 1;
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam logic [c_pw-1:0] c_full    = c_pw'(DEPTH);
    localparam logic [c_pw-1:0] c_one     = c_pw'(1);
    localparam logic [c_tw-1:0] c_timeout = c_tw'(TIMEOUT);

    // Expected-entry storage; pointers carry one extra wrap bit
    logic [31:0]     r_dst  [DEPTH];
    logic [1:0]      r_dm   [DEPTH];
    logic [31:0]     r_data [DEPTH];
    logic [31:0]     r_src  [DEPTH];
    logic [DEPTH-1:0] r_bad;

    logic [c_pw-1:0] r_wr_ptr, r_aw_idx, r_w_idx;
    logic [c_tw-1:0] r_idle;
    logic            r_aw_stall, r_w_stall;
    logic [31:0]     r_awaddr_q;
    logic [63:0]     r_wdata_q;

    logic [c_iw-1:0] w_wr_slot, w_aw_slot, w_w_slot, w_lag_slot;
    logic            w_push, w_push_ok, w_ovf;
    logic            w_aw_hs, w_aw_adv, w_aw_unexp, w_aw_fail;
    logic            w_w_hs, w_w_adv, w_w_unexp, w_w_fail;
    logic [2:0]      w_a;
    logic [7:0]      w_exp_strb;
    logic [63:0]     w_exp_data, w_byte_mask;
    logic [c_pw-1:0] w_d_aw, w_d_w, w_d_aw_n, w_d_w_n, w_pend, w_pend_n, w_pend_nxt, w_lag_idx;
    logic            w_retire, w_full, w_retire_bad, w_match;
    logic [c_tw-1:0] w_idle_nxt;
    logic            w_proto;
    logic            w_unused;

    assign w_unused = ^{wr_packet[7:3], wr_packet[0]};

    assign w_wr_slot = r_wr_ptr[c_iw-1:0];
    assign w_aw_slot = r_aw_idx[c_iw-1:0];
    assign w_w_slot  = r_w_idx[c_iw-1:0];

    assign w_push  = wr_access & ~wr_wait;
    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;

    // Checks see the pre-push pointer, so a same-cycle push never self-matches
    assign w_aw_adv   = w_aw_hs & (r_aw_idx != r_wr_ptr);
    assign w_aw_unexp = w_aw_hs & (r_aw_idx == r_wr_ptr);
    assign w_w_adv    = w_w_hs & (r_w_idx != r_wr_ptr);
    assign w_w_unexp  = w_w_hs & (r_w_idx == r_wr_ptr);

    assign w_aw_fail = (m_axi_awaddr != r_dst[w_aw_slot])
                     | (m_axi_awsize != {1'b0, r_dm[w_aw_slot]})
                     | (m_axi_awlen != 8'd0)
                     | (m_axi_awburst != 2'b01);

    assign w_a = r_dst[w_w_slot][2:0];

    always_comb begin
        w_exp_strb = 8'hFF;
        case (r_dm[w_w_slot])
            2'd0:    w_exp_strb = 8'h01 << w_a;
            2'd1:    w_exp_strb = 8'h03 << {w_a[2:1], 1'b0};
            2'd2:    w_exp_strb = 8'h0F << {w_a[2], 2'b00};
            default: w_exp_strb = 8'hFF;
        endcase
        w_byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_byte_mask[8*i +: 8] = {8{w_exp_strb[i]}};
        end
    end

    assign w_exp_data = (r_dm[w_w_slot] == 2'd3) ? {r_src[w_w_slot], r_data[w_w_slot]}
                                                 : {r_data[w_w_slot], r_data[w_w_slot]};

    assign w_w_fail = (m_axi_wstrb != w_exp_strb)
                    | ~m_axi_wlast
                    | (((m_axi_wdata ^ w_exp_data) & w_byte_mask) != 64'd0);

    // Occupancy is set by whichever index lags furthest behind the write pointer
    assign w_d_aw    = r_wr_ptr - r_aw_idx;
    assign w_d_w     = r_wr_ptr - r_w_idx;
    assign w_lag_idx = (w_d_aw >= w_d_w) ? r_aw_idx : r_w_idx;
    assign w_pend    = (w_d_aw >= w_d_w) ? w_d_aw : w_d_w;
    assign w_d_aw_n  = w_d_aw - {{(c_pw-1){1'b0}}, w_aw_adv};
    assign w_d_w_n   = w_d_w - {{(c_pw-1){1'b0}}, w_w_adv};
    assign w_pend_n  = (w_d_aw_n >= w_d_w_n) ? w_d_aw_n : w_d_w_n;
    assign w_retire  = (w_pend_n != w_pend);
    assign w_lag_slot = w_lag_idx[c_iw-1:0];

    assign w_full     = (w_pend == c_full);
    assign w_push_ok  = w_push & (~w_full | w_retire);
    assign w_ovf      = w_push & w_full & ~w_retire;
    assign w_pend_nxt = w_pend_n + {{(c_pw-1){1'b0}}, w_push_ok};

    assign w_retire_bad = r_bad[w_lag_slot]
                        | (w_aw_adv & w_aw_fail & (r_aw_idx == w_lag_idx))
                        | (w_w_adv & w_w_fail & (r_w_idx == w_lag_idx));
    assign w_match = w_retire & ~w_retire_bad;

    assign w_idle_nxt = (w_aw_hs | w_w_hs | (pending == '0)) ? '0
                      : (r_idle == c_timeout) ? r_idle : r_idle + c_tw'(1);

    assign w_proto = (r_aw_stall & (~m_axi_awvalid | (m_axi_awaddr != r_awaddr_q)))
                   | (r_w_stall & (~m_axi_wvalid | (m_axi_wdata != r_wdata_q)));

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_dst[w_wr_slot]  <= wr_packet[39:8];
            r_dm[w_wr_slot]   <= wr_packet[2:1];
            r_data[w_wr_slot] <= wr_packet[71:40];
            r_src[w_wr_slot]  <= wr_packet[103:72];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr       <= '0;
            r_aw_idx       <= '0;
            r_w_idx        <= '0;
            r_bad          <= '0;
            r_idle         <= '0;
            r_aw_stall     <= 1'b0;
            r_w_stall      <= 1'b0;
            r_awaddr_q     <= '0;
            r_wdata_q      <= '0;
            err_addr       <= 1'b0;
            err_data       <= 1'b0;
            err_proto      <= 1'b0;
            err_timeout    <= 1'b0;
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
            pending        <= '0;
            match_cnt      <= '0;
        end else begin
            if (w_aw_adv) begin
                r_aw_idx <= r_aw_idx + c_one;
                if (w_aw_fail) begin
                    r_bad[w_aw_slot] <= 1'b1;
                    err_addr         <= 1'b1;
                end
            end
            if (w_w_adv) begin
                r_w_idx <= r_w_idx + c_one;
                if (w_w_fail) begin
                    r_bad[w_w_slot] <= 1'b1;
                    err_data        <= 1'b1;
                end
            end
            // Push last so a slot freed by this cycle's retire starts clean
            if (w_push_ok) begin
                r_wr_ptr         <= r_wr_ptr + c_one;
                r_bad[w_wr_slot] <= 1'b0;
            end
            if (w_ovf)
                err_overflow <= 1'b1;
            if (w_aw_unexp | w_w_unexp)
                err_unexpected <= 1'b1;
            if (w_proto)
                err_proto <= 1'b1;
            if (w_idle_nxt == c_timeout)
                err_timeout <= 1'b1;
            if (w_match && (match_cnt != '1))
                match_cnt <= match_cnt + CW'(1);
            pending    <= w_pend_nxt;
            r_idle     <= w_idle_nxt;
            r_aw_stall <= m_axi_awvalid & ~m_axi_awready;
            r_w_stall  <= m_axi_wvalid & ~m_axi_wready;
            r_awaddr_q <= m_axi_awaddr;
            r_wdata_q  <= m_axi_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/emaxi_wr_checker.md
EMAXI_WR_CHECKER -- requirements
Module: emaxi_wr_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the max number of accepted eMesh writes tracked; power of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning idle cycles allowed with pending writes before a timeout error.
REQ-003 SHALL have parameter CW, default 16, meaning the width of the match counter.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_access, wr_wait  input  1 each  eMesh write request and backpressure.
REQ-007 SHALL have port wr_packet  input  104  eMesh packet: [0] write, [2:1] datamode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
REQ-008 SHALL have ports m_axi_awvalid, m_axi_awready  input  1 each, m_axi_awaddr  input  32, m_axi_awlen  input  8, m_axi_awsize  input  3, m_axi_awburst  input  2.
REQ-009 SHALL have ports m_axi_wvalid, m_axi_wready, m_axi_wlast  input  1 each, m_axi_wdata  input  64, m_axi_wstrb  input  8.
REQ-010 SHALL have ports err_addr, err_data, err_proto, err_timeout, err_overflow, err_unexpected  output  1 each  sticky error flags.
REQ-011 SHALL have port pending  output  $clog2(DEPTH)+1  number of tracked, not-yet-retired writes.
REQ-012 SHALL have port match_cnt  output  CW  count of fully matched writes, saturating at all-ones.

Function
REQ-013 SHALL push an expected entry {dstaddr, datamode, data, srcaddr} on every cycle with wr_access=1 and wr_wait=0.
REQ-014 SHALL treat an AW handshake as awvalid&awready and a W handshake as wvalid&wready.
REQ-015 SHALL keep independent AW and W read indices so AW and W may arrive in either order and up to DEPTH apart.
REQ-016 SHALL check on each AW handshake against the entry at the AW index: awaddr==dstaddr, awsize=={1'b0,datamode}, awlen==0, awburst==2'b01; any mismatch sets err_addr; then advance AW index.
REQ-017 SHALL derive the expected wstrb from datamode and dstaddr[2:0]: 0 -> 8'h01<<a[2:0], 1 -> 8'h03<<{a[2:1],1'b0}, 2 -> 8'h0F<<{a[2],2'b00}, 3 -> 8'hFF.
REQ-018 SHALL take the expected wdata as {srcaddr,data} for datamode 3, else {data,data}.
REQ-019 SHALL check on each W handshake: wstrb equal to the expected strobe, wlast==1, and wdata equal to expected data on strobed bytes only; any mismatch sets err_data; then advance W index.
REQ-020 SHALL retire an entry once both indices have passed it, with pending = wr_ptr minus the lagging index.
REQ-021 SHALL increment match_cnt once per retired entry that raised no error on either check.
REQ-022 SHALL set err_unexpected on an AW or W handshake when its own index equals wr_ptr (nothing to check); the index SHALL NOT advance in that case.
REQ-023 SHALL set err_overflow on a push with pending==DEPTH; the push SHALL be dropped and no other state change.
REQ-024 SHALL treat a push and a retire in the same cycle when full as retire-first: no overflow, pending unchanged.
REQ-025 SHALL make same-cycle push and handshakes on an empty queue not self-match: the check sees the pre-push state and raises err_unexpected.
REQ-026 SHALL set err_proto when awvalid (or wvalid) falls without a handshake, or when awaddr (or wdata) changes while valid and not ready.
REQ-027 SHALL run an idle counter that clears on any AW/W handshake or when pending==0, and increments otherwise.
REQ-028 SHALL set err_timeout when the idle counter reaches TIMEOUT; the counter SHALL saturate.
REQ-029 SHALL keep error flags sticky until reset; checking SHALL continue after an error.
REQ-030 SHALL register all outputs, visible one cycle after the causing handshake.

Reset
REQ-031 SHALL, while rstn=0, asynchronously clear pointers, indices, idle counter, match_cnt, pending and all error flags to 0.
REQ-032 SHALL discard all in-flight entries on reset assertion mid-operation, with no error raised for them after release.

Verification
REQ-033 SHALL be verified: one push (dstaddr=0x8000_0004, datamode=2, data=0xDEADBEEF), then AW addr 0x8000_0004 size 2, then W strb 0xF0 data 0xDEADBEEF_xxxxxxxx -> match_cnt=1, pending=0, no errors.
REQ-034 SHALL be verified: W before AW for a datamode-3 write with srcaddr=0x1, data=0x2 -> wdata 0x00000001_00000002, strb 0xFF accepted, match_cnt=1.
REQ-035 SHALL be verified: DEPTH pushes with no handshakes, then one more -> err_overflow=1, pending=DEPTH; TIMEOUT cycles later -> err_timeout=1.
REQ-036 SHALL be verified: AW handshake on an empty queue -> err_unexpected=1, pending=0; a byte write with strb 0x01 at addr offset 3 -> err_data=1.
REQ-037 SHALL be verified: awvalid dropped before awready -> err_proto=1; rstn pulsed low with 2 pending -> all outputs 0, and subsequent clean traffic reports no errors.
